// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating the single RAM port between
// instruction fetch and the load/store buffer, with round-robin grants.
module mem_ctrl #(
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   IO_BASE    = 32'h30000,
  localparam int unsigned            DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_signal,
  input  logic                  if_query_en,
  input  logic [ADDR_WIDTH-1:0] if_query_addr,
  output logic                  if_reply_en,
  output logic [DATA_WIDTH-1:0] if_reply_data,
  input  logic                  lsb_query_en,
  input  logic                  lsb_query_type,
  input  logic [ADDR_WIDTH-1:0] lsb_query_addr,
  input  logic [1:0]            lsb_data_width,
  input  logic [DATA_WIDTH-1:0] lsb_query_data,
  output logic                  lsb_reply_en,
  output logic [DATA_WIDTH-1:0] lsb_reply_data,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  localparam int unsigned CNT_WIDTH = 3;
  localparam int unsigned IO_SPAN   = 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic {SRC_IF, SRC_LSB} src_t;

  state_t                state, state_n;
  src_t                  last_grant, last_grant_n, src, src_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n, mem_a_n;
  logic [CNT_WIDTH-1:0]  nbytes, nbytes_n, k, k_n;
  logic [DATA_WIDTH-1:0] wdata, wdata_n, rdata, rdata_n;
  logic [7:0]            mem_dout_n;
  logic                  mem_wr_n;
  logic                  if_reply_en_n, lsb_reply_en_n;
  logic [DATA_WIDTH-1:0] if_reply_data_n, lsb_reply_data_n;

  logic [ADDR_WIDTH-1:0] byte_addr;
  logic [1:0]            cap_idx;
  logic [DATA_WIDTH-1:0] rdata_cap;
  logic                  io_stall;
  logic                  grant_if, grant_lsb;
  logic [CNT_WIDTH-1:0]  lsb_nbytes;

  // Datapath helpers: RAM data arrives two edges after its address is driven
  always_comb begin
    byte_addr = addr + ADDR_WIDTH'(k);
    cap_idx   = 2'(k - CNT_WIDTH'(2));
    rdata_cap = rdata | (DATA_WIDTH'(mem_din) << {cap_idx, 3'b000});
    io_stall  = io_buffer_full && ((byte_addr - IO_BASE) < ADDR_WIDTH'(IO_SPAN));
    grant_if  = if_query_en && (!lsb_query_en || last_grant == SRC_LSB);
    grant_lsb = lsb_query_en && !grant_if;
    case (lsb_data_width)
      2'd0:    lsb_nbytes = CNT_WIDTH'(1);
      2'd1:    lsb_nbytes = CNT_WIDTH'(2);
      default: lsb_nbytes = CNT_WIDTH'(4);
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n          = state;
    last_grant_n     = last_grant;
    src_n            = src;
    addr_n           = addr;
    nbytes_n         = nbytes;
    k_n              = k;
    wdata_n          = wdata;
    rdata_n          = rdata;
    mem_a_n          = mem_a;
    mem_dout_n       = mem_dout;
    mem_wr_n         = mem_wr;
    if_reply_en_n    = 1'b0;
    lsb_reply_en_n   = 1'b0;
    if_reply_data_n  = if_reply_data;
    lsb_reply_data_n = lsb_reply_data;

    case (state)
      IDLE: begin
        if (!flush_signal && (grant_if || grant_lsb)) begin
          k_n     = '0;
          rdata_n = '0;
          if (grant_if) begin
            src_n        = SRC_IF;
            last_grant_n = SRC_IF;
            addr_n       = if_query_addr;
            nbytes_n     = CNT_WIDTH'(4);
            wdata_n      = '0;
            state_n      = READ;
          end else begin
            src_n        = SRC_LSB;
            last_grant_n = SRC_LSB;
            addr_n       = lsb_query_addr;
            nbytes_n     = lsb_nbytes;
            wdata_n      = lsb_query_data;
            state_n      = lsb_query_type ? WRITE : READ;
          end
        end
      end
      READ: begin
        // A completing reply wins over a same-edge flush
        if (k == nbytes + CNT_WIDTH'(1)) begin
          if (src == SRC_IF) begin
            if_reply_en_n   = 1'b1;
            if_reply_data_n = rdata_cap;
          end else begin
            lsb_reply_en_n   = 1'b1;
            lsb_reply_data_n = rdata_cap;
          end
          rdata_n = rdata_cap;
          state_n = DONE;
        end else if (flush_signal) begin
          mem_a_n = '0;
          state_n = IDLE;
        end else begin
          if (k < nbytes) mem_a_n = byte_addr;
          if (k >= CNT_WIDTH'(2)) rdata_n = rdata_cap;
          mem_wr_n = 1'b0;
          k_n      = k + CNT_WIDTH'(1);
        end
      end
      WRITE: begin
        // Committed stores ignore flush; IO window writes stall on a full buffer
        if (k == nbytes) begin
          mem_wr_n       = 1'b0;
          lsb_reply_en_n = 1'b1;
          state_n        = DONE;
        end else begin
          mem_a_n    = byte_addr;
          mem_dout_n = 8'(wdata >> {k[1:0], 3'b000});
          if (io_stall) begin
            mem_wr_n = 1'b0;
          end else begin
            mem_wr_n = 1'b1;
            k_n      = k + CNT_WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      last_grant     <= SRC_LSB;
      src            <= SRC_IF;
      addr           <= '0;
      nbytes         <= '0;
      k              <= '0;
      wdata          <= '0;
      rdata          <= '0;
      mem_a          <= '0;
      mem_dout       <= '0;
      mem_wr         <= 1'b0;
      if_reply_en    <= 1'b0;
      lsb_reply_en   <= 1'b0;
      if_reply_data  <= '0;
      lsb_reply_data <= '0;
    end else if (rdy_in) begin
      state          <= state_n;
      last_grant     <= last_grant_n;
      src            <= src_n;
      addr           <= addr_n;
      nbytes         <= nbytes_n;
      k              <= k_n;
      wdata          <= wdata_n;
      rdata          <= rdata_n;
      mem_a          <= mem_a_n;
      mem_dout       <= mem_dout_n;
      mem_wr         <= mem_wr_n;
      if_reply_en    <= if_reply_en_n;
      lsb_reply_en   <= lsb_reply_en_n;
      if_reply_data  <= if_reply_data_n;
      lsb_reply_data <= lsb_reply_data_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: synchronous byte RAM model, expected
// read data queued per requester and compared when the reply pulses.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_signal = 1'b0;
  logic        if_query_en = 1'b0;
  logic [31:0] if_query_addr = '0;
  logic        if_reply_en;
  logic [31:0] if_reply_data;
  logic        lsb_query_en = 1'b0;
  logic        lsb_query_type = 1'b0;
  logic [31:0] lsb_query_addr = '0;
  logic [1:0]  lsb_data_width = '0;
  logic [31:0] lsb_query_data = '0;
  logic        lsb_reply_en;
  logic [31:0] lsb_reply_data;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] if_exp_q[$];
  logic [31:0] lsb_exp_q[$];
  logic [31:0] wr_a[$];
  logic [7:0]  wr_d[$];
  logic [7:0]  ram [0:262143];

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_signal(flush_signal),
    .if_query_en(if_query_en), .if_query_addr(if_query_addr),
    .if_reply_en(if_reply_en), .if_reply_data(if_reply_data),
    .lsb_query_en(lsb_query_en), .lsb_query_type(lsb_query_type),
    .lsb_query_addr(lsb_query_addr), .lsb_data_width(lsb_data_width),
    .lsb_query_data(lsb_query_data), .lsb_reply_en(lsb_reply_en),
    .lsb_reply_data(lsb_reply_data), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM with registered read port, stalled together with the chip
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
      mem_din <= ram[mem_a[17:0]];
    end
    if (rst_in && rdy_in && mem_wr) begin
      wr_a.push_back(mem_a);
      wr_d.push_back(mem_dout);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    if_query_en = 1'b0;
    lsb_query_en = 1'b0;
    flush_signal = 1'b0;
    io_buffer_full = 1'b0;
    rdy_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic lsb_req(input logic typ, input logic [31:0] a, input logic [1:0] w,
                         input logic [31:0] d);
    lsb_query_type = typ;
    lsb_query_addr = a;
    lsb_data_width = w;
    lsb_query_data = d;
    lsb_query_en = 1'b1;
  endtask

  // n = number of edges observed up to and including the reply edge
  task automatic wait_reply(input bit is_if, input int budget, output int n,
                            output logic [31:0] d, output bit ok);
    ok = 1'b0;
    n = 0;
    d = '0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (is_if ? if_reply_en : lsb_reply_en) begin
        n = i;
        d = is_if ? if_reply_data : lsb_reply_data;
        ok = 1'b1;
        if (is_if) if_query_en = 1'b0;
        else lsb_query_en = 1'b0;
        break;
      end
    end
    if (!ok) begin
      if_query_en = 1'b0;
      lsb_query_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    #2;
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a: got %h expected 00000000", mem_a); end
    checks++; if (mem_wr !== 1'b0 || mem_dout !== 8'h00) begin errors++; $display("FAIL reset_mem_wr_dout: got %b/%h expected 0/00", mem_wr, mem_dout); end
    checks++; if (if_reply_en !== 1'b0 || lsb_reply_en !== 1'b0) begin errors++; $display("FAIL reset_reply_en: got %b/%b expected 0/0", if_reply_en, lsb_reply_en); end
    checks++; if (if_reply_data !== 32'h0 || lsb_reply_data !== 32'h0) begin errors++; $display("FAIL reset_reply_data: got %h/%h expected 0/0", if_reply_data, lsb_reply_data); end
    do_reset();
  endtask

  task automatic test_if_read();
    int n; logic [31:0] d; bit ok; logic [31:0] exp;
    wr_a.delete(); wr_d.delete();
    if_query_addr = 32'h1000;
    if_query_en = 1'b1;
    if_exp_q.push_back(32'h0000_0513);
    wait_reply(1'b1, 20, n, d, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL if_read_timeout: got no reply expected reply");
      if_exp_q.delete();
    end else begin
      exp = if_exp_q.pop_front();
      if (d !== exp) begin errors++; $display("FAIL if_read_data: got %h expected %h", d, exp); end
      checks++; if (n - 1 != 6) begin errors++; $display("FAIL if_read_latency: got %0d expected 6", n - 1); end
    end
    tick();
    checks++; if (if_reply_en !== 1'b0) begin errors++; $display("FAIL if_reply_pulse: got %b expected 0", if_reply_en); end
    checks++; if (wr_a.size() != 0) begin errors++; $display("FAIL if_read_no_write: got %0d writes expected 0", wr_a.size()); end
  endtask

  task automatic test_lsb_store_load();
    int n; logic [31:0] d; bit ok; logic [31:0] exp;
    wr_a.delete(); wr_d.delete();
    lsb_req(1'b1, 32'h2002, 2'd1, 32'hABCD1234);
    wait_reply(1'b0, 20, n, d, ok);
    checks++; if (!ok || n - 1 != 3) begin errors++; $display("FAIL sh_latency: got %0d expected 3", ok ? n - 1 : -1); end
    tick();
    checks++;
    if (wr_a.size() != 2) begin
      errors++; $display("FAIL sh_write_count: got %0d expected 2", wr_a.size());
    end else begin
      if (wr_a[0] !== 32'h2002 || wr_d[0] !== 8'h34) begin errors++; $display("FAIL sh_byte0: got %h/%h expected 00002002/34", wr_a[0], wr_d[0]); end
      checks++; if (wr_a[1] !== 32'h2003 || wr_d[1] !== 8'h12) begin errors++; $display("FAIL sh_byte1: got %h/%h expected 00002003/12", wr_a[1], wr_d[1]); end
    end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL sh_wr_clear: got %b expected 0", mem_wr); end
    lsb_req(1'b0, 32'h2003, 2'd0, 32'h0);
    lsb_exp_q.push_back(32'h0000_0012);
    wait_reply(1'b0, 20, n, d, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL lb_timeout: got no reply expected reply");
      lsb_exp_q.delete();
    end else begin
      exp = lsb_exp_q.pop_front();
      if (d !== exp) begin errors++; $display("FAIL lb_data: got %h expected %h", d, exp); end
      checks++; if (n - 1 != 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", n - 1); end
    end
    tick();
  endtask

  task automatic test_arbitration();
    int order[$]; bit if_rearm; bit lsb_rearm; logic [31:0] exp;
    if_rearm = 1'b0; lsb_rearm = 1'b0;
    do_reset();
    if_query_addr = 32'h1000;
    if_query_en = 1'b1;
    if_exp_q.push_back(32'h0000_0513);
    lsb_req(1'b0, 32'h2100, 2'd2, 32'h0);
    lsb_exp_q.push_back(32'h4433_2211);
    for (int c = 0; c < 80 && order.size() < 3; c++) begin
      tick();
      if (if_rearm) begin if_query_en = 1'b1; if_exp_q.push_back(32'h0000_0513); if_rearm = 1'b0; end
      if (lsb_rearm) begin lsb_query_en = 1'b1; lsb_exp_q.push_back(32'h4433_2211); lsb_rearm = 1'b0; end
      if (if_reply_en && lsb_reply_en) begin checks++; errors++; $display("FAIL arb_dual_reply: got 1/1 expected one"); end
      if (if_reply_en) begin
        order.push_back(0);
        exp = if_exp_q.pop_front();
        checks++; if (if_reply_data !== exp) begin errors++; $display("FAIL arb_if_data: got %h expected %h", if_reply_data, exp); end
        if_query_en = 1'b0; if_rearm = 1'b1;
      end
      if (lsb_reply_en) begin
        order.push_back(1);
        exp = lsb_exp_q.pop_front();
        checks++; if (lsb_reply_data !== exp) begin errors++; $display("FAIL arb_lsb_data: got %h expected %h", lsb_reply_data, exp); end
        lsb_query_en = 1'b0; lsb_rearm = 1'b1;
      end
    end
    if_query_en = 1'b0;
    lsb_query_en = 1'b0;
    if_exp_q.delete();
    lsb_exp_q.delete();
    tick(); tick();
    checks++;
    if (order.size() != 3) begin
      errors++; $display("FAIL arb_count: got %0d expected 3", order.size());
    end else begin
      if (order[0] != 0 || order[1] != 1 || order[2] != 0)
        begin errors++; $display("FAIL arb_order: got %0d%0d%0d expected 010", order[0], order[1], order[2]); end
    end
  endtask

  task automatic test_io_stall();
    int n; logic [31:0] d; bit ok; int stalled_wr;
    stalled_wr = 0;
    wr_a.delete(); wr_d.delete();
    lsb_req(1'b1, 32'h30000, 2'd0, 32'h0000_0041);
    tick();
    io_buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_wr !== 1'b0) stalled_wr++;
    end
    io_buffer_full = 1'b0;
    checks++; if (stalled_wr != 0) begin errors++; $display("FAIL io_stall_wr: got %0d cycles with wr expected 0", stalled_wr); end
    wait_reply(1'b0, 20, n, d, ok);
    checks++; if (!ok || 4 + n - 1 != 5) begin errors++; $display("FAIL io_latency: got %0d expected 5", ok ? 4 + n - 1 : -1); end
    tick();
    checks++;
    if (wr_a.size() != 1) begin
      errors++; $display("FAIL io_write_count: got %0d expected 1", wr_a.size());
    end else if (wr_a[0] !== 32'h30000 || wr_d[0] !== 8'h41) begin
      errors++; $display("FAIL io_write: got %h/%h expected 00030000/41", wr_a[0], wr_d[0]);
    end
  endtask

  task automatic test_flush();
    int n; logic [31:0] d; bit ok; int stray; logic [31:0] exp;
    stray = 0;
    if_query_addr = 32'h1000;
    if_query_en = 1'b1;
    tick();
    tick();
    flush_signal = 1'b1;
    tick();
    flush_signal = 1'b0;
    if_query_en = 1'b0;
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL flush_read_mem_a: got %h expected 00000000", mem_a); end
    for (int i = 0; i < 10; i++) begin
      if (if_reply_en !== 1'b0) stray++;
      tick();
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL flush_read_reply: got %0d pulses expected 0", stray); end
    checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL flush_read_idle: got %h expected 00000000", mem_a); end

    wr_a.delete(); wr_d.delete();
    lsb_req(1'b1, 32'h2200, 2'd2, 32'hDEADBEEF);
    tick();
    tick();
    flush_signal = 1'b1;
    tick();
    flush_signal = 1'b0;
    wait_reply(1'b0, 20, n, d, ok);
    checks++; if (!ok || 3 + n - 1 != 5) begin errors++; $display("FAIL flush_sw_latency: got %0d expected 5", ok ? 3 + n - 1 : -1); end
    tick();
    checks++;
    if (wr_a.size() != 4) begin
      errors++; $display("FAIL flush_sw_count: got %0d expected 4", wr_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] word;
        word = 32'hDEADBEEF >> (8 * i);
        checks++;
        if (wr_a[i] !== 32'h2200 + 32'(i) || wr_d[i] !== word[7:0])
          begin errors++; $display("FAIL flush_sw_byte%0d: got %h/%h expected %h/%h", i, wr_a[i], wr_d[i], 32'h2200 + 32'(i), word[7:0]); end
      end
    end
    lsb_req(1'b0, 32'h2200, 2'd2, 32'h0);
    lsb_exp_q.push_back(32'hDEADBEEF);
    wait_reply(1'b0, 20, n, d, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL lw_after_sw_timeout: got no reply expected reply");
      lsb_exp_q.delete();
    end else begin
      exp = lsb_exp_q.pop_front();
      if (d !== exp) begin errors++; $display("FAIL lw_after_sw: got %h expected %h", d, exp); end
    end
    tick();
  endtask

  task automatic test_rdy_freeze();
    int n; logic [31:0] d; bit ok; logic [31:0] held_a; int moved; logic [31:0] exp;
    moved = 0;
    lsb_req(1'b0, 32'h2100, 2'd2, 32'h0);
    lsb_exp_q.push_back(32'h4433_2211);
    tick();
    tick();
    tick();
    held_a = mem_a;
    checks++; if (held_a !== 32'h2101) begin errors++; $display("FAIL freeze_pre_addr: got %h expected 00002101", held_a); end
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_a !== held_a || lsb_reply_en !== 1'b0 || mem_wr !== 1'b0) moved++;
    end
    rdy_in = 1'b1;
    checks++; if (moved != 0) begin errors++; $display("FAIL freeze_hold: got %0d changed cycles expected 0", moved); end
    wait_reply(1'b0, 30, n, d, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL freeze_timeout: got no reply expected reply");
      lsb_exp_q.delete();
    end else begin
      exp = lsb_exp_q.pop_front();
      if (d !== exp) begin errors++; $display("FAIL freeze_data: got %h expected %h", d, exp); end
      checks++; if (8 + n - 1 != 11) begin errors++; $display("FAIL freeze_latency: got %0d expected 11", 8 + n - 1); end
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    int n; logic [31:0] d; bit ok; logic [31:0] exp;
    lsb_req(1'b1, 32'h2300, 2'd2, 32'h01020304);
    tick();
    tick();
    checks++; if (mem_wr !== 1'b1 || mem_dout !== 8'h04) begin errors++; $display("FAIL prereset_write: got %b/%h expected 1/04", mem_wr, mem_dout); end
    rst_in = 1'b0;
    #1;
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL async_reset_wr: got %b expected 0", mem_wr); end
    checks++; if (mem_a !== 32'h0 || mem_dout !== 8'h00) begin errors++; $display("FAIL async_reset_bus: got %h/%h expected 0/0", mem_a, mem_dout); end
    lsb_query_en = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    if_query_addr = 32'h1000;
    if_query_en = 1'b1;
    if_exp_q.push_back(32'h0000_0513);
    wait_reply(1'b1, 20, n, d, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL post_reset_timeout: got no reply expected reply");
      if_exp_q.delete();
    end else begin
      exp = if_exp_q.pop_front();
      if (d !== exp || n - 1 != 6) begin errors++; $display("FAIL post_reset_read: got %h lat %0d expected %h lat 6", d, n - 1, exp); end
    end
    tick();
  endtask

  initial begin
    ram[18'h01000] = 8'h13; ram[18'h01001] = 8'h05;
    ram[18'h01002] = 8'h00; ram[18'h01003] = 8'h00;
    ram[18'h02100] = 8'h11; ram[18'h02101] = 8'h22;
    ram[18'h02102] = 8'h33; ram[18'h02103] = 8'h44;
    test_reset();
    test_if_read();
    test_lsb_store_load();
    test_arbitration();
    test_io_stall();
    test_flush();
    test_rdy_freeze();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that shares the single byte-wide RAM port between the instruction fetcher (IF) and the load/store buffer (LSB). Requests of 1/2/4 bytes are serialised into per-byte RAM accesses, read bytes are reassembled little-endian, and a one-cycle reply pulse is returned to the requester. Arbitration is round-robin. Flush aborts reads, while committed stores always complete.

## Interface
- ADDR_WIDTH, 32, byte address width
- IO_BASE, 32'h30000, first address of the memory-mapped IO window (8 bytes)

- clk_in  input  1  clock, rising edge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global ready; low = full freeze
- flush_signal  input  1  pipeline flush from RoB
- if_query_en  input  1  IF word-read request, level-held until reply
- if_query_addr  input  32  IF fetch address
- if_reply_en  output  1  one-cycle pulse, IF data valid
- if_reply_data  output  32  fetched instruction word
- lsb_query_en  input  1  LSB request, level-held until reply
- lsb_query_type  input  1  0 read, 1 write
- lsb_query_addr  input  32  LSB byte address
- lsb_data_width  input  2  0 byte, 1 half, 2/3 word
- lsb_query_data  input  32  store data, low bytes used
- lsb_reply_en  output  1  one-cycle pulse, LSB access complete
- lsb_reply_data  output  32  load data, zero in unused upper bytes
- mem_din  input  8  RAM read byte, valid one cycle after its address is presented
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 write, 0 read
- io_buffer_full  input  1  IO output buffer cannot accept a write

## Operation
- States: IDLE, READ, WRITE, DONE.
- Reset (rst_in low, asynchronous):
  - state is IDLE and last_grant is LSB, so IF wins the first tie.
  - mem_a, mem_dout, mem_wr, both reply_en and both reply_data registers are 0.
- rdy_in low: every register holds, including outputs.
- IDLE:
  - Requesters are sampled and arbitrated. If only one is pending, it is granted.
  - If both are pending, the one not equal to last_grant is granted, and last_grant is updated.
  - The grant latches source, addr, byte count N (1/2/4), type and data. IF is always read, N=4.
  - The byte counter k is cleared, then the state moves to READ or WRITE.
- READ:
  - The address for byte k=0..N-1 is driven on mem_a as addr+k, one byte per cycle, with mem_wr=0.
  - mem_din is sampled one cycle later into bits [8k+7:8k].
  - After byte N-1 is captured, the selected reply_en is pulsed with the assembled data and the state moves to DONE.
- WRITE:
  - Each cycle mem_a=addr+k, mem_dout=data[8k+7:8k] and mem_wr=1.
  - If addr is in [IO_BASE, IO_BASE+7] and io_buffer_full=1, mem_wr is forced to 0 and k does not advance (stall).
  - After byte N-1 is written, mem_wr is cleared to 0, lsb_reply_en is pulsed and the state moves to DONE.
- DONE:
  - Lasts exactly one cycle and ignores requests, because requesters drop query_en on the edge after the reply.
  - Then the state returns to IDLE.
- Address arithmetic is modulo 2^32. The byte offset never exceeds 3.
- Flush:
  - In READ, the access is aborted. There is no reply, mem_a is driven to 0 and the state moves to IDLE.
  - In WRITE, the write continues to completion and the reply is still issued.
  - In IDLE, no request is granted on the flush edge.
  - In DONE, no effect.
- A reply pulse and a flush on the same edge: the reply is still pulsed.

## Timing
- Request accepted at edge T (IDLE, query_en=1).
- Read: mem_a is driven at edges T+1..T+N. reply_en is high in the cycle after edge T+N+2.
  - Word read latency: 6 cycles from accept to reply.
  - Byte read latency: 3 cycles.
- Write (no IO stall): bytes are driven at edges T+1..T+N. reply_en is asserted at edge T+N+1, giving latency N+1.
- Each IO-full stall cycle adds 1 cycle.
- DONE follows the reply, so the next grant occurs no earlier than 2 edges after the reply edge.
- reply_en is never high for more than 1 cycle. Only one reply_en is high at a time.

## Test plan
- IF-only read at 0x1000 (RAM 0x1000..3 = 13 05 00 00) -> if_reply_en pulses once, 6 cycles after accept, with if_reply_data=0x00000513. mem_wr stays 0 throughout.
- LSB sh of 0xABCD1234 at 0x2002 -> mem_a 0x2002 then 0x2003, with mem_dout 0x34 then 0x12 and mem_wr=1. lsb_reply_en follows 3 cycles after accept. A subsequent lb at 0x2003 returns 0x00000012.
- IF and LSB lw both request from reset -> IF is served first, then LSB. With both continuously re-requesting, grants alternate IF, LSB, IF.
- sb 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles. One write of 0x41 then occurs, and the reply arrives 3 cycles later than the unstalled case.
- flush_signal during the 2nd byte of an IF read -> no if_reply_en, state returns to IDLE. flush during an LSB sw -> all 4 bytes are written and lsb_reply_en still pulses.
- rst_in low mid-WRITE -> mem_wr=0, outputs are 0 and state is IDLE immediately, without waiting for a clock edge. rdy_in low for 5 cycles mid-read -> outputs frozen, and the data is correct on resume.
